branch_steer: RTL and testbench

- Dataflow steering operator that consumes the boolean token produced by the compare stages (equality compare and its siblings) and routes a paired data token to a "true" or "false" output.
- Sits directly downstream of a compare operator. The compare's R_OUT/D_OUT drives this block's condition input; the data input comes from any producer.
- Condition and data tokens may arrive in different cycles. Small per-input token buffers pair them in arrival order.

---
 rtl/branch_steer_pkg.sv | 11 +
 rtl/branch_steer_token_fifo.sv | 64 ++++++
 rtl/branch_steer.sv | 110 +++++++++++
 tb/tb_branch_steer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/branch_steer_pkg.sv
// Shared constants and sizing helpers for the branch_steer operator.
package branch_steer_pkg;
   localparam int DEFAULT_N     = 16;
   localparam int DEFAULT_DEPTH = 4;
   localparam int STATS_W       = 32;

   // Occupancy counters need one extra bit so "full" (== DEPTH) is representable.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction
endpackage

// File: rtl/branch_steer_token_fifo.sv
// Small FIFO token buffer with combinational head and overflow pulse.
// Pointers wrap naturally because DEPTH is a power of two.
module token_fifo
   import branch_steer_pkg::*;
#(
   parameter int W     = 1,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         empty,
   output logic         full,
   output logic         ovf_pulse
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));
   assign dout  = mem[rd_ptr_q];

   always_comb begin
      do_pop    = pop && !empty;
      // A simultaneous pop frees the slot the push needs.
      do_push   = push && (!full || do_pop);
      ovf_pulse = push && full && !do_pop;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= din;
   end
endmodule

// File: rtl/branch_steer.sv
// Steers a data token to the true/false output according to a paired condition token.
// Optional BRANCH_STEER_STATS_EN adds TAKEN_CNT / NTAKEN_CNT pulse counters.
module branch_steer
   import branch_steer_pkg::*;
#(
   parameter int N     = DEFAULT_N,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         EN,
   input  logic         R_IN1,
   input  logic [N-1:0] D_IN1,
   input  logic         R_IN2,
   input  logic [N-1:0] D_IN2,
   output logic         R_OUT_T,
   output logic [N-1:0] D_OUT_T,
   output logic         R_OUT_F,
   output logic [N-1:0] D_OUT_F,
   output logic         OVF
`ifdef BRANCH_STEER_STATS_EN
   ,
   output logic [STATS_W-1:0] TAKEN_CNT,
   output logic [STATS_W-1:0] NTAKEN_CNT
`endif
);
   logic         c_push, c_pop, c_empty, c_full, c_ovf;
   logic [0:0]   c_head;
   logic         d_push, d_pop, d_empty, d_full, d_ovf;
   logic [N-1:0] d_head;
   logic         fire, cond_sel;
   logic [N-1:0] data_sel;
   logic         r_t_q, r_t_d, r_f_q, r_f_d, ovf_q, ovf_d;
   logic [N-1:0] d_t_q, d_t_d, d_f_q, d_f_d;
   logic         unused_full;

   // Full flags are implied by the overflow pulses; kept only for observability.
   assign unused_full = c_full ^ d_full;

   token_fifo #(.W(1), .DEPTH(DEPTH)) u_cond_fifo (
      .clk(CLK), .rst_n(RST), .push(c_push), .pop(c_pop), .din(|D_IN1),
      .dout(c_head), .empty(c_empty), .full(c_full), .ovf_pulse(c_ovf)
   );

   token_fifo #(.W(N), .DEPTH(DEPTH)) u_data_fifo (
      .clk(CLK), .rst_n(RST), .push(d_push), .pop(d_pop), .din(D_IN2),
      .dout(d_head), .empty(d_empty), .full(d_full), .ovf_pulse(d_ovf)
   );

   always_comb begin
      fire     = EN && (!c_empty || R_IN1) && (!d_empty || R_IN2);
      // Buffered tokens are older than live ones, so the head wins.
      cond_sel = c_empty ? (|D_IN1) : c_head[0];
      data_sel = d_empty ? D_IN2 : d_head;
      c_pop    = fire && !c_empty;
      d_pop    = fire && !d_empty;
      c_push   = EN && R_IN1 && !(fire && c_empty);
      d_push   = EN && R_IN2 && !(fire && d_empty);
      r_t_d    = fire && cond_sel;
      r_f_d    = fire && !cond_sel;
      d_t_d    = r_t_d ? data_sel : d_t_q;
      d_f_d    = r_f_d ? data_sel : d_f_q;
      ovf_d    = ovf_q || c_ovf || d_ovf;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_t_q <= 1'b0;
         r_f_q <= 1'b0;
         d_t_q <= '0;
         d_f_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         r_t_q <= r_t_d;
         r_f_q <= r_f_d;
         d_t_q <= d_t_d;
         d_f_q <= d_f_d;
         ovf_q <= ovf_d;
      end
   end

   assign R_OUT_T = r_t_q;
   assign R_OUT_F = r_f_q;
   assign D_OUT_T = d_t_q;
   assign D_OUT_F = d_f_q;
   assign OVF     = ovf_q;

`ifdef BRANCH_STEER_STATS_EN
   logic [STATS_W-1:0] taken_q, taken_d, ntaken_q, ntaken_d;

   // Counters advance on the same edge that raises the corresponding pulse.
   always_comb begin
      taken_d  = taken_q  + STATS_W'(r_t_d);
      ntaken_d = ntaken_q + STATS_W'(r_f_d);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         taken_q  <= '0;
         ntaken_q <= '0;
      end else begin
         taken_q  <= taken_d;
         ntaken_q <= ntaken_d;
      end
   end

   assign TAKEN_CNT  = taken_q;
   assign NTAKEN_CNT = ntaken_q;
`endif
endmodule

// File: tb/tb_branch_steer.sv
// Scoreboard bench for branch_steer: queue-based reference model plus decoupled output monitor.
module tb_branch_steer;
   localparam int N     = 16;
   localparam int DEPTH = 4;

   typedef struct {
      int           tag;
      logic         is_t;
      logic [N-1:0] data;
   } exp_t;

   logic         CLK = 1'b0;
   logic         RST = 1'b0;
   logic         EN = 1'b0;
   logic         R_IN1 = 1'b0;
   logic [N-1:0] D_IN1 = '0;
   logic         R_IN2 = 1'b0;
   logic [N-1:0] D_IN2 = '0;
   logic         R_OUT_T, R_OUT_F, OVF;
   logic [N-1:0] D_OUT_T, D_OUT_F;
`ifdef BRANCH_STEER_STATS_EN
   logic [31:0]  TAKEN_CNT, NTAKEN_CNT;
`endif

   branch_steer #(.N(N), .DEPTH(DEPTH)) dut (
      .CLK(CLK), .RST(RST), .EN(EN),
      .R_IN1(R_IN1), .D_IN1(D_IN1), .R_IN2(R_IN2), .D_IN2(D_IN2),
      .R_OUT_T(R_OUT_T), .D_OUT_T(D_OUT_T), .R_OUT_F(R_OUT_F), .D_OUT_F(D_OUT_F),
      .OVF(OVF)
`ifdef BRANCH_STEER_STATS_EN
      , .TAKEN_CNT(TAKEN_CNT), .NTAKEN_CNT(NTAKEN_CNT)
`endif
   );

   always #5 CLK = ~CLK;

   int   checks = 0;
   int   errors = 0;
   int   edge_cnt = 0;
   exp_t exp_q[$];
   logic cq[$];
   logic [N-1:0] dq[$];
   logic ovf_m = 1'b0;
   logic [N-1:0] last_t = '0, last_f = '0;
   int   taken_m = 0, ntaken_m = 0;

   always @(posedge CLK) edge_cnt++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (edge %0d)", name, act, req, edge_cnt);
      end
   endtask

   // Reference model: tokens are queued in arrival order and the oldest pair is matched.
   task automatic step(input logic en, input logic r1, input logic [N-1:0] d1,
                       input logic r2, input logic [N-1:0] d2);
      logic fire, c, cbyp, dbyp;
      logic [N-1:0] d;
      EN = en; R_IN1 = r1; D_IN1 = d1; R_IN2 = r2; D_IN2 = d2;
      if (en) begin
         fire = (cq.size() > 0 || r1) && (dq.size() > 0 || r2);
         cbyp = fire && cq.size() == 0;
         dbyp = fire && dq.size() == 0;
         c = 1'b0; d = '0;
         if (fire) begin
            c = cbyp ? (d1 != 0) : cq.pop_front();
            d = dbyp ? d2 : dq.pop_front();
         end
         if (r1 && !cbyp) begin
            if (cq.size() < DEPTH) cq.push_back(d1 != 0); else ovf_m = 1'b1;
         end
         if (r2 && !dbyp) begin
            if (dq.size() < DEPTH) dq.push_back(d2); else ovf_m = 1'b1;
         end
         if (fire) exp_q.push_back('{tag: edge_cnt + 1, is_t: c, data: d});
      end
      @(posedge CLK);
      #1;
      chk("ovf", 32'(OVF), 32'(ovf_m));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b0, '0);
   endtask

   // Monitor: compares each output cycle against the scoreboard head.
   always @(negedge CLK) begin
      if (!RST) begin
         last_t = '0; last_f = '0; taken_m = 0; ntaken_m = 0;
      end else begin
         exp_t e;
         chk("exclusive", 32'(R_OUT_T && R_OUT_F), 32'd0);
         while (exp_q.size() > 0 && exp_q[0].tag < edge_cnt) begin
            e = exp_q.pop_front();
            chk("missing_pulse", 32'd0, 32'(e.data));
         end
         if (exp_q.size() > 0 && exp_q[0].tag == edge_cnt) begin
            e = exp_q.pop_front();
            chk("r_out_t", 32'(R_OUT_T), 32'(e.is_t));
            chk("r_out_f", 32'(R_OUT_F), 32'(!e.is_t));
            if (e.is_t) begin
               last_t = e.data; taken_m++;
            end else begin
               last_f = e.data; ntaken_m++;
            end
            chk("d_out_t", 32'(D_OUT_T), 32'(last_t));
            chk("d_out_f", 32'(D_OUT_F), 32'(last_f));
         end else begin
            chk("idle_valid", 32'({R_OUT_T, R_OUT_F}), 32'd0);
            chk("hold_d_t", 32'(D_OUT_T), 32'(last_t));
            chk("hold_d_f", 32'(D_OUT_F), 32'(last_f));
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_r_t", 32'(R_OUT_T), 32'd0);
      chk("rst_r_f", 32'(R_OUT_F), 32'd0);
      chk("rst_ovf", 32'(OVF), 32'd0);
      RST = 1'b1;

      // Aligned pair
      step(1'b1, 1'b1, 16'h0001, 1'b1, 16'h00AB);
      idle(2);
      // Skewed arrival
      step(1'b1, 1'b1, 16'h0000, 1'b0, '0);
      idle(2);
      step(1'b1, 1'b0, '0, 1'b1, 16'h1234);
      idle(2);
      // Ordering
      step(1'b1, 1'b1, 16'h0001, 1'b0, '0);
      step(1'b1, 1'b1, 16'h0000, 1'b0, '0);
      step(1'b1, 1'b1, 16'h0005, 1'b0, '0);
      step(1'b1, 1'b0, '0, 1'b1, 16'h0011);
      step(1'b1, 1'b0, '0, 1'b1, 16'h0022);
      step(1'b1, 1'b0, '0, 1'b1, 16'h0033);
      idle(2);
      // Overflow: five conditions into a four-entry buffer
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, N'(i & 1), 1'b0, '0);
      chk("ovf_set", 32'(OVF), 32'd1);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0, 1'b1, N'(16'h0100 + i));
      idle(3);
      chk("ovf_sticky", 32'(OVF), 32'd1);

      // EN freeze with buffered data
      step(1'b1, 1'b0, '0, 1'b1, 16'h0A0A);
      step(1'b1, 1'b0, '0, 1'b1, 16'h0B0B);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h0001, 1'b1, 16'hDEAD);
      step(1'b1, 1'b1, 16'h0001, 1'b0, '0);
      // Asynchronous reset while the pulse is on the output
      RST = 1'b0;
      while (exp_q.size() > 0 && exp_q[exp_q.size()-1].tag >= edge_cnt) exp_q.pop_back();
      cq.delete(); dq.delete(); ovf_m = 1'b0;
      #1;
      chk("async_r_t", 32'(R_OUT_T), 32'd0);
      chk("async_d_t", 32'(D_OUT_T), 32'd0);
      chk("async_ovf", 32'(OVF), 32'd0);
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b1;
      // Buffers must be empty: a lone condition cannot fire
      step(1'b1, 1'b1, 16'h0000, 1'b0, '0);
      idle(2);
      step(1'b1, 1'b0, '0, 1'b1, 16'h7777);
      idle(2);

      // Randomized traffic with phase-varying rates
      for (int i = 0; i < 1500; i++) begin
         int p1, p2;
         p1 = (i / 250) % 3;
         p2 = ((i / 250) + 1) % 3;
         step(($urandom_range(0, 9) != 0),
              ($urandom_range(0, 3) < 1 + p1),
              ($urandom_range(0, 1) != 0) ? N'($urandom) : '0,
              ($urandom_range(0, 3) < 1 + p2),
              N'($urandom));
      end
      idle(4);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
`ifdef BRANCH_STEER_STATS_EN
      chk("taken_cnt", TAKEN_CNT, 32'(taken_m));
      chk("ntaken_cnt", NTAKEN_CNT, 32'(ntaken_m));
      RST = 1'b0;
      #1;
      chk("taken_rst", TAKEN_CNT, 32'd0);
      chk("ntaken_rst", NTAKEN_CNT, 32'd0);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
